spectrum_upload_reader: RTL and testbench



---
 rtl/spectrum_upload_reader_pkg.sv | 40 ++++
 rtl/spectrum_upload_reader_seg_ram_sdp.sv | 29 ++
 rtl/spectrum_upload_reader.sv | 186 ++++++++++++++++++
 tb/tb_spectrum_upload_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_upload_reader_pkg.sv
// Shared definitions for the spectrum upload reader: segment geometry,
// FSM state encoding, header field layout and the header packing helper.
package spectrum_upload_reader_pkg;

   localparam int SEG_LEN = 2048;
   localparam int SEG_AW  = $clog2(SEG_LEN);

   localparam logic [7:0] HDR_TAG = 8'hA5;
   localparam int HDR_TAG_LSB     = 24;
   localparam int HDR_FCNT_LSB    = 16;
   localparam int HDR_FLAG_LO_BIT = 11;
   localparam int HDR_FLAG_HI_BIT = 12;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TRIG    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_HEADER  = 3'd3,
      ST_PAYLOAD = 3'd4,
      ST_TRAILER = 3'd5
   } state_t;

   // Header = {tag, frame count, word count}. When a trailer follows, a flag
   // goes in bit 11, or in bit 12 when bit 11 is already part of the count.
   function automatic logic [31:0] make_header(input logic [7:0]  fcnt,
                                               input logic [15:0] count,
                                               input logic        trailer);
      logic [31:0] hdr;
      hdr = '0;
      hdr[HDR_TAG_LSB +: 8]  = HDR_TAG;
      hdr[HDR_FCNT_LSB +: 8] = fcnt;
      hdr[15:0]              = count;
      if (trailer) begin
         if (count[HDR_FLAG_LO_BIT]) hdr[HDR_FLAG_HI_BIT] = 1'b1;
         else                        hdr[HDR_FLAG_LO_BIT] = 1'b1;
      end
      return hdr;
   endfunction

endpackage

// File: rtl/spectrum_upload_reader_seg_ram_sdp.sv
// Simple dual-port segment RAM: one synchronous write port and one
// synchronous read port with a single cycle of read latency.
module seg_ram_sdp #(
   parameter int DEPTH = spectrum_upload_reader_pkg::SEG_LEN,
   parameter int AW    = spectrum_upload_reader_pkg::SEG_AW,
   parameter int DW    = 64
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // registered read port
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/spectrum_upload_reader.sv
// Spectrum upload reader: triggers the accumulation buffer, captures one
// segment of 64-bit words into local RAM, then streams a header and the
// segment as 32-bit words (high half first) with valid/ready handshake.
// Optional trailer checksum: define SPECTRUM_CHECKSUM_EN.
module spectrum_upload_reader #(
   parameter int SEG_LEN = spectrum_upload_reader_pkg::SEG_LEN,
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        upload_en,
   input  logic [63:0] data_in,
   input  logic        valid_in,
   output logic        trigger_start,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        drop_err
);

   import spectrum_upload_reader_pkg::*;

   localparam int AW  = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
   localparam int WCW = $clog2(SEG_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);
`ifdef SPECTRUM_CHECKSUM_EN
   localparam logic HAS_TRAILER = 1'b1;
`else
   localparam logic HAS_TRAILER = 1'b0;
`endif

   state_t           state_reg, state_next;
   logic [WCW-1:0]   wcnt_reg;
   logic [TCW-1:0]   tcnt_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [WCW-1:0]   word_idx_reg;
   logic             on_lo_reg;
   logic [31:0]      lo_reg;
   logic [7:0]       frame_cnt_reg;
   logic [31:0]      out_data_reg;
   logic             out_valid_reg;
   logic             out_last_reg;
   logic             drop_err_reg;
   logic [63:0]      ram_q;

   logic [WCW-1:0]   wcnt_inc;
   logic             seg_full, timed_out, xfer, last_word;
   logic             pay_end, trl_end, frame_end;
   logic             cap_done, ld_hi, ld_lo, ram_we, ram_re;

   assign wcnt_inc  = wcnt_reg + WCW'(valid_in);
   assign seg_full  = (wcnt_inc == WCW'(SEG_LEN));
   assign timed_out = (tcnt_reg == TCW'(TIMEOUT - 1));
   assign xfer      = out_valid_reg && out_ready;
   assign last_word = ((word_idx_reg + 1'b1) == wcnt_reg);
   assign pay_end   = (state_reg == ST_PAYLOAD) && xfer && on_lo_reg && last_word;
   assign trl_end   = (state_reg == ST_TRAILER) && xfer;
   assign frame_end = (pay_end && !HAS_TRAILER) || trl_end;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // FSM next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (upload_en) state_next = ST_TRIG;
         ST_TRIG:    state_next = ST_CAPTURE;
         ST_CAPTURE: begin
            if (seg_full)       state_next = ST_HEADER;
            else if (timed_out) state_next = (wcnt_inc == '0) ? ST_IDLE : ST_HEADER;
         end
         ST_HEADER:  if (xfer) state_next = ST_PAYLOAD;
         ST_PAYLOAD: if (pay_end) state_next = HAS_TRAILER ? ST_TRAILER : ST_IDLE;
         ST_TRAILER: if (xfer) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // FSM outputs and datapath strobes
   always_comb begin
      trigger_start = (state_reg == ST_TRIG);
      busy          = (state_reg != ST_IDLE);
      ram_we        = (state_reg == ST_CAPTURE) && valid_in;
      cap_done      = (state_reg == ST_CAPTURE) && (state_next == ST_HEADER);
      // next high half comes from the prefetched word; the low half is parked in lo_reg
      ld_hi         = ((state_reg == ST_HEADER) && xfer) ||
                      ((state_reg == ST_PAYLOAD) && xfer && on_lo_reg && !last_word);
      ld_lo         = (state_reg == ST_PAYLOAD) && xfer && !on_lo_reg;
      // prefetch word 0 as the header is loaded, then one word ahead per high half
      ram_re        = cap_done || ld_hi;
   end

   seg_ram_sdp #(.DEPTH(SEG_LEN), .AW(AW), .DW(64)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wcnt_reg[AW-1:0]),
      .wdata (data_in),
      .re    (ram_re),
      .raddr (rd_ptr_reg),
      .rdata (ram_q)
   );

   // capture counters, read pointer, frame counter and sticky drop flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_reg      <= '0;
         tcnt_reg      <= '0;
         rd_ptr_reg    <= '0;
         frame_cnt_reg <= '0;
         drop_err_reg  <= 1'b0;
      end else begin
         if (state_reg == ST_TRIG) begin
            wcnt_reg   <= '0;
            tcnt_reg   <= '0;
            rd_ptr_reg <= '0;
         end
         if (state_reg == ST_CAPTURE) begin
            wcnt_reg <= wcnt_inc;
            tcnt_reg <= tcnt_reg + 1'b1;
         end
         if (ram_re) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (frame_end) frame_cnt_reg <= frame_cnt_reg + 1'b1;
         if (valid_in && (state_reg != ST_CAPTURE)) drop_err_reg <= 1'b1;
      end
   end

`ifdef SPECTRUM_CHECKSUM_EN
   logic [31:0] sum_reg;

   // running sum of every payload word placed on the output
   always_ff @(posedge clk) begin
      if (rst)                        sum_reg <= '0;
      else if (state_reg == ST_TRIG)  sum_reg <= '0;
      else if (ld_hi)                 sum_reg <= sum_reg + ram_q[63:32];
      else if (ld_lo)                 sum_reg <= sum_reg + lo_reg;
   end
`endif

   // output register: only reloaded on a transfer or when it is empty
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         lo_reg        <= '0;
         on_lo_reg     <= 1'b0;
         word_idx_reg  <= '0;
      end else if (cap_done) begin
         out_data_reg  <= make_header(frame_cnt_reg, 16'(wcnt_inc), HAS_TRAILER);
         out_valid_reg <= 1'b1;
         out_last_reg  <= 1'b0;
      end else if (ld_hi) begin
         out_data_reg  <= ram_q[63:32];
         lo_reg        <= ram_q[31:0];
         on_lo_reg     <= 1'b0;
         word_idx_reg  <= (state_reg == ST_HEADER) ? '0 : word_idx_reg + 1'b1;
      end else if (ld_lo) begin
         out_data_reg  <= lo_reg;
         on_lo_reg     <= 1'b1;
         out_last_reg  <= last_word && !HAS_TRAILER;
      end else if (pay_end) begin
`ifdef SPECTRUM_CHECKSUM_EN
         out_data_reg  <= sum_reg;
         out_last_reg  <= 1'b1;
`else
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
`endif
      end else if (trl_end) begin
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;
   assign drop_err  = drop_err_reg;

endmodule

// File: tb/tb_spectrum_upload_reader.sv
// Testbench for spectrum_upload_reader. Uses a reduced segment (16 words)
// and timeout (64 cycles) so that 257 frames fit a short run. Expected
// frames are built from the captured words: header, hi/lo halves, trailer.
module tb_spectrum_upload_reader;

   localparam int SEG = 16;
   localparam int TMO = 64;

   logic        clk, rst, upload_en, valid_in, out_ready;
   logic [63:0] data_in;
   logic        trigger_start, out_valid, out_last, busy, drop_err;
   logic [31:0] out_data;

   int total = 0;
   int bad   = 0;
   int fcnt_m = 0;
   logic [63:0] words[$];
   logic [31:0] exp_q[$];

   spectrum_upload_reader #(.SEG_LEN(SEG), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .upload_en(upload_en), .data_in(data_in),
      .valid_in(valid_in), .trigger_start(trigger_start), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .drop_err(drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; valid_in = 1'b0; out_ready = 1'b0; data_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      fcnt_m = 0;
   endtask

   task automatic wait_trigger();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         seen = trigger_start;
      end
      check("trigger_seen", 32'(seen), 32'd1);
   endtask

   // kind 0: data=i, 1: data=1, 2: random; words past SEG are discarded
   task automatic capture(input int n, input int kind);
      logic [63:0] w;
      words.delete();
      for (int i = 0; i < n; i++) begin
         w = (kind == 0) ? 64'(i) : (kind == 1) ? 64'd1 : {$urandom, $urandom};
         @(negedge clk);
         if (i == 0) check("trig_one_cycle", 32'(trigger_start), 32'd0);
         valid_in = 1'b1;
         data_in  = w;
         if (i < SEG) words.push_back(w);
      end
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = '0;
   endtask

   function automatic void build_frame();
      logic [15:0] low;
      logic [31:0] sum;
      exp_q.delete();
      low = 16'(words.size());
`ifdef SPECTRUM_CHECKSUM_EN
      if (low[11]) low[12] = 1'b1;
      else         low[11] = 1'b1;
`endif
      exp_q.push_back({8'hA5, 8'(fcnt_m), low});
      sum = 0;
      foreach (words[i]) begin
         exp_q.push_back(words[i][63:32]);
         exp_q.push_back(words[i][31:0]);
         sum = sum + words[i][63:32] + words[i][31:0];
      end
`ifdef SPECTRUM_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
   endfunction

   // rmode 0: ready held high; 1: random ready. drop_at: transfer count at which upload_en falls
   task automatic drain(input int rmode, input int drop_at);
      int idx, cyc, first_x, last_x;
      bit held;
      logic [31:0] hd;
      logic hl;
      idx = 0; cyc = 0; held = 1'b0; first_x = -1; last_x = 0; hd = '0; hl = 1'b0;
      while (idx < exp_q.size() && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (held) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, hd);
            check("stall_last", 32'(out_last), 32'(hl));
         end
         out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         held = out_valid && !out_ready;
         hd = out_data;
         hl = out_last;
         if (out_valid && out_ready) begin
            check($sformatf("word%0d", idx), out_data, exp_q[idx]);
            check($sformatf("last%0d", idx), 32'(out_last), 32'(idx == exp_q.size() - 1));
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            idx++;
            if (idx == drop_at) upload_en = 1'b0;
         end
      end
      check("drain_count", 32'(idx), 32'(exp_q.size()));
      if (rmode == 0) check("no_bubble", 32'(last_x - first_x), 32'(exp_q.size() - 1));
      @(negedge clk);
      out_ready = 1'b0;
      check("end_valid", 32'(out_valid), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
      fcnt_m++;
   endtask

   initial begin
      int n, cyc;
      bit saw;
      upload_en = 1'b0;
      do_reset();

      // reset state
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_trig", 32'(trigger_start), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_drop", 32'(drop_err), 32'd0);
      check("rst_data", out_data, 32'd0);

      // stray word while idle
      @(negedge clk); valid_in = 1'b1; data_in = 64'hDEAD;
      @(negedge clk); valid_in = 1'b0;
      check("drop_idle", 32'(drop_err), 32'd1);
      check("idle_stays", 32'(busy), 32'd0);

      // full segment, data=i, ready held high
      upload_en = 1'b1;
      wait_trigger();
      upload_en = 1'b0;
      capture(SEG, 0);
      build_frame();
      drain(0, -1);
      check("drop_sticky", 32'(drop_err), 32'd1);

      // backpressure with the same data
      do_reset();
      check("drop_cleared", 32'(drop_err), 32'd0);
      upload_en = 1'b1;
      wait_trigger();
      upload_en = 1'b0;
      capture(SEG, 0);
      build_frame();
      drain(1, -1);
      check("no_false_drop", 32'(drop_err), 32'd0);

      // short frame
      upload_en = 1'b1;
      wait_trigger();
      upload_en = 1'b0;
      capture(5, 2);
      build_frame();
      drain(1, -1);

      // no words at all: timeout back to idle without output
      upload_en = 1'b1;
      wait_trigger();
      upload_en = 1'b0;
      saw = 1'b0;
      cyc = 0;
      for (int c = 0; c < TMO + 20; c++) begin
         @(negedge clk);
         cyc++;
         saw = saw | out_valid;
         if (!busy) break;
      end
      check("empty_no_output", 32'(saw), 32'd0);
      check("empty_timeout_len", 32'(cyc), 32'(TMO + 1));

      // one word beyond the segment is discarded
      upload_en = 1'b1;
      wait_trigger();
      upload_en = 1'b0;
      capture(SEG + 1, 2);
      build_frame();
      check("extra_drop", 32'(drop_err), 32'd1);
      drain(0, -1);

      // upload_en falls during payload: frame completes, no new trigger
      do_reset();
      upload_en = 1'b1;
      wait_trigger();
      capture(SEG, 2);
      build_frame();
      drain(1, 10);
      n = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (trigger_start) n++;
      end
      check("no_retrigger", 32'(n), 32'd0);

      // reset in the middle of the payload
      upload_en = 1'b1;
      wait_trigger();
      upload_en = 1'b0;
      capture(SEG, 2);
      n = 0;
      for (int c = 0; c < 200 && n < 6; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (out_valid) n++;
      end
      check("mid_progress", 32'(n), 32'd6);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      out_ready = 1'b0;
      fcnt_m = 0;

      // 257 back-to-back frames: frame counter wraps in the last header
      upload_en = 1'b1;
      for (int k = 0; k < 257; k++) begin
         wait_trigger();
         capture(SEG, (k % 3 == 0) ? 1 : 2);
         build_frame();
         drain(k % 2, -1);
      end
      upload_en = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
